// File: rtl/mc_pkg.sv
// mc_pkg: shared engine commands, engine states and scheduler FSM encoding
package mc_pkg;
  localparam int MW_DEF = 512;
  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_LOAD = 4'd1;
  localparam logic [3:0] CMD_CALC = 4'd2;
  localparam logic [3:0] CMD_READ = 4'd3;
  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_IN   = 2'd1;
  localparam logic [1:0] MC_CALC = 2'd2;
  localparam logic [1:0] MC_OUT  = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WLOAD, S_CALC, S_WCALC, S_READ, S_WREAD, S_FIN
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or above rr_ptr, wrapping around
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic            any_o,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o
);
  logic [NREQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign rot = NREQ'({req_i, req_i} >> rr_ptr_i);
  assign any_o = |req_i;
  // lowest set bit of the rotated vector is the distance from rr_ptr to the winner
  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
  end
  assign sum = {1'b0, rr_ptr_i} + {1'b0, off};
  assign idx_o = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
  assign pick_o = any_o ? NREQ'(1) << idx_o : '0;
endmodule

// File: rtl/mc_job_scheduler.sv
// mc_job_scheduler: round-robin sharing of one matrix_calculator, one whole job per grant
module mc_job_scheduler
  import mc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MW = MW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*MW-1:0] req_matrix,
  output logic [NREQ-1:0]  gnt,
  output logic             done,
  output logic             err,
  output logic [MW-1:0]    result_data,
  output logic [3:0]       mc_command,
  output logic [MW-1:0]    mc_matrix_in,
  input  logic [1:0]       mc_state,
  input  logic [MW-1:0]    mc_matrix_out
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, pick;
  logic [IW-1:0] idx_q, idx_d, rr_ptr_q, rr_ptr_d, pick_idx, idx_next;
  logic [TW-1:0] timer_q, timer_d;
  logic [MW-1:0] result_q, result_d;
  logic seen_busy_q, seen_busy_d, any_req, waiting, tmo;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i(req),
    .rr_ptr_i(rr_ptr_q),
    .any_o(any_req),
    .pick_o(pick),
    .idx_o(pick_idx)
  );

  assign waiting = state_q inside {S_WLOAD, S_WCALC, S_WREAD};
  assign tmo = waiting && timer_q == TW'(TIMEOUT - 1);
  assign idx_next = idx_q == IW'(NREQ - 1) ? '0 : idx_q + 1'b1;
  assign gnt = gnt_q;
  assign result_data = result_q;

  // state and datapath registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      rr_ptr_q <= '0;
      timer_q <= '0;
      seen_busy_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q <= timer_d;
      seen_busy_q <= seen_busy_d;
      result_q <= result_d;
    end
  end

  // job sequencing; a timeout in any wait state abandons the job and moves past its owner
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    rr_ptr_d = rr_ptr_q;
    seen_busy_d = seen_busy_q;
    result_d = result_q;
    timer_d = waiting && timer_q != '1 ? timer_q + 1'b1 : '0;
    if (tmo) begin
      state_d = S_IDLE;
      gnt_d = '0;
      rr_ptr_d = idx_next;
    end else begin
      case (state_q)
        S_IDLE: if (any_req) begin
          state_d = S_LOAD;
          gnt_d = pick;
          idx_d = pick_idx;
        end
        S_LOAD: state_d = S_WLOAD;
        S_WLOAD: if (mc_state == MC_IN) state_d = S_CALC;
        S_CALC: begin
          state_d = S_WCALC;
          seen_busy_d = 1'b0;
        end
        S_WCALC: begin
          seen_busy_d = seen_busy_q | (mc_state == MC_CALC);
          if (seen_busy_q && mc_state == MC_IDLE) state_d = S_READ;
        end
        S_READ: state_d = S_WREAD;
        S_WREAD: if (mc_state == MC_OUT) begin
          state_d = S_FIN;
          result_d = mc_matrix_out;
        end
        S_FIN: begin
          state_d = S_IDLE;
          gnt_d = '0;
          rr_ptr_d = idx_next;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // engine command, status pulses and granted-matrix mux
  always_comb begin
    mc_command = state_q == S_LOAD ? CMD_LOAD : state_q == S_CALC ? CMD_CALC :
                 state_q == S_READ ? CMD_READ : CMD_NOP;
    done = state_q == S_FIN;
    err = tmo;
    mc_matrix_in = '0;
    for (int i = 0; i < NREQ; i++) mc_matrix_in = mc_matrix_in | (gnt_q[i] ? req_matrix[i*MW +: MW] : '0);
  end
endmodule

// File: tb/tb_mc_job_scheduler.sv
// tb_mc_job_scheduler: scoreboard bench with a behavioural matrix_calculator model
module tb_mc_job_scheduler;
  import mc_pkg::*;
  localparam int NREQ = 4;
  localparam int MW = 512;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic is_err;
    logic [MW-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req;
  logic [NREQ*MW-1:0] req_matrix;
  logic [NREQ-1:0] gnt;
  logic done, err;
  logic [MW-1:0] result_data, mc_matrix_in, mout, ld;
  logic [3:0] mc_command;
  logic [1:0] mst;
  logic [MW-1:0] mats [NREQ];
  int d_load, d_calc, d_read, ph, cnt;
  bit stuck;
  int n_cmp, n_bad, n_done, n_err;
  exp_t exp_q[$];
  exp_t sb;
  logic [3:0] cmd_log[$];

  always #5 clk = ~clk;

  mc_job_scheduler #(.NREQ(NREQ), .MW(MW), .TIMEOUT(64)) dut (
    .CLK(clk),
    .reset(rst),
    .req(req),
    .req_matrix(req_matrix),
    .gnt(gnt),
    .done(done),
    .err(err),
    .result_data(result_data),
    .mc_command(mc_command),
    .mc_matrix_in(mc_matrix_in),
    .mc_state(mst),
    .mc_matrix_out(mout)
  );

  function automatic logic [MW-1:0] calc(input logic [MW-1:0] m);
    return {m[MW/2-1:0], m[MW-1:MW/2]} ^ {16{32'hA5A5_5A5A}};
  endfunction

  function automatic logic [MW-1:0] rnd512();
    logic [MW-1:0] v;
    v = '0;
    for (int i = 0; i < MW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // engine model: LOAD shows state 1 for one cycle after d_load, CALC shows state 2 for
  // d_calc cycles (never if stuck), READ shows state 3 with C after d_read
  always @(posedge clk) begin
    if (rst) begin
      mst <= MC_IDLE;
      ph <= 0;
      cnt <= 0;
      mout <= '0;
    end else if (mc_command == CMD_LOAD) begin
      ld <= mc_matrix_in;
      ph <= 1;
      cnt <= d_load;
    end else if (mc_command == CMD_CALC) begin
      ph <= stuck ? 0 : 2;
      cnt <= d_calc;
      mst <= stuck ? MC_IDLE : MC_CALC;
    end else if (mc_command == CMD_READ) begin
      ph <= 3;
      cnt <= d_read;
    end else if (ph == 0) begin
      mst <= MC_IDLE;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else begin
      ph <= 0;
      mst <= ph == 1 ? MC_IN : ph == 3 ? MC_OUT : MC_IDLE;
      if (ph == 3) mout <= calc(ld);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (mc_command != CMD_NOP) cmd_log.push_back(mc_command);
      if (done) n_done++;
      if (err) n_err++;
      n_cmp++;
      if (!$onehot0(gnt) || (done && err)) begin
        n_bad++;
        $display("FAIL gnt_onehot_excl: gnt=%b done=%b err=%b want one-hot-or-zero gnt and not both", gnt, done, err);
      end
      if (done || err) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_end: done=%b err=%b gnt=%b with no job expected", done, err, gnt);
        end else begin
          sb = exp_q.pop_front();
          n_cmp++;
          if (err !== sb.is_err) begin
            n_bad++;
            $display("FAIL job_kind: err=%b want %b", err, sb.is_err);
          end
          n_cmp++;
          if (gnt !== sb.gnt) begin
            n_bad++;
            $display("FAIL job_gnt: gnt=%b want %b", gnt, sb.gnt);
          end
          n_cmp++;
          if (result_data !== sb.res) begin
            n_bad++;
            $display("FAIL job_result: got %h want %h", result_data, sb.res);
          end
        end
      end
    end
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (result_data !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_data); end
    n_cmp++; if (mc_command !== CMD_NOP) begin n_bad++; $display("FAIL reset_cmd: got %0d want 0", mc_command); end
    n_cmp++; if (mc_matrix_in !== '0) begin n_bad++; $display("FAIL reset_matrix_in: got %h want 0", mc_matrix_in); end
  endtask

  task automatic test_single();
    bit ok;
    int d0;
    d_load = 1; d_calc = 3; d_read = 1;
    cmd_log.delete();
    d0 = n_done;
    req = 4'b0001;
    exp_q.push_back('{gnt: 4'b0001, is_err: 1'b0, res: calc(mats[0])});
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt_latency: got %b want 0001", gnt); end
    n_cmp++; if (mc_matrix_in !== mats[0]) begin n_bad++; $display("FAIL single_matrix_in: got %h want %h", mc_matrix_in, mats[0]); end
    wait_empty(100, ok);
    req = '0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: job not ended, %0d pending", exp_q.size()); end
    n_cmp++;
    if (cmd_log.size() != 3 || cmd_log[0] !== CMD_LOAD || cmd_log[1] !== CMD_CALC || cmd_log[2] !== CMD_READ) begin
      n_bad++;
      $display("FAIL single_cmd_seq: %0d commands seen, want LOAD,CALC,READ", cmd_log.size());
    end
    repeat (10) tick();
    n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", n_done - d0); end
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL single_gnt_release: got %b want 0", gnt); end
  endtask

  task automatic test_all();
    bit ok;
    int e0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_load = 2; d_calc = 2; d_read = 2;
    e0 = n_err;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back('{gnt: 4'b0001 << (i % 4), is_err: 1'b0, res: calc(mats[i % 4])});
    wait_empty(300, ok);
    req = '0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL all_timeout: %0d jobs pending", exp_q.size()); end
    n_cmp++; if (n_err !== e0) begin n_bad++; $display("FAIL all_err: got %0d err pulses want 0", n_err - e0); end
  endtask

  task automatic test_rr_ptr();
    bit ok;
    d_load = 1; d_calc = 3; d_read = 1;
    req = 4'b0101;
    exp_q.push_back('{gnt: 4'b0100, is_err: 1'b0, res: calc(mats[2])});
    exp_q.push_back('{gnt: 4'b0001, is_err: 1'b0, res: calc(mats[0])});
    wait_empty(200, ok);
    req = '0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: %0d jobs pending", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int calc_c, err_c;
    stuck = 1'b1;
    calc_c = -1;
    err_c = -1;
    req = 4'b0110;
    exp_q.push_back('{gnt: 4'b0010, is_err: 1'b1, res: calc(mats[0])});
    exp_q.push_back('{gnt: 4'b0100, is_err: 1'b0, res: calc(mats[2])});
    for (int c = 0; c < 300 && err_c < 0; c++) begin
      tick();
      if (mc_command == CMD_CALC) calc_c = c;
      if (err) err_c = c;
    end
    stuck = 1'b0;
    n_cmp++; if (err_c - calc_c !== 64) begin n_bad++; $display("FAIL tmo_latency: err at %0d calc at %0d want 64 apart", err_c, calc_c); end
    tick();
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL tmo_gnt: got %b want 0", gnt); end
    n_cmp++; if (result_data !== calc(mats[0])) begin n_bad++; $display("FAIL tmo_result_kept: got %h want %h", result_data, calc(mats[0])); end
    wait_empty(200, ok);
    req = '0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_next_job: %0d jobs pending", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    d_calc = 10;
    seen = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (mc_command == CMD_CALC) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_calc: got no CALC want CALC"); end
    repeat (3) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rstmid_gnt: got %b want 0", gnt); end
    n_cmp++; if (mc_command !== CMD_NOP) begin n_bad++; $display("FAIL rstmid_cmd: got %0d want 0", mc_command); end
    n_cmp++; if (result_data !== '0) begin n_bad++; $display("FAIL rstmid_result: got %h want 0", result_data); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_pulses: done=%b err=%b want 0 0", done, err); end
    n_cmp++; if (mc_matrix_in !== '0) begin n_bad++; $display("FAIL rstmid_matrix_in: got %h want 0", mc_matrix_in); end
    rst = 1'b0;
    d_calc = 3;
    exp_q.push_back('{gnt: 4'b0001, is_err: 1'b0, res: calc(mats[0])});
    wait_empty(200, ok);
    req = '0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_rerun: %0d jobs pending", exp_q.size()); end
  endtask

  task automatic test_drop();
    bit ok, seen;
    int extra;
    seen = 1'b0;
    req = 4'b0001;
    exp_q.push_back('{gnt: 4'b0001, is_err: 1'b0, res: calc(mats[0])});
    exp_q.push_back('{gnt: 4'b0100, is_err: 1'b0, res: calc(mats[2])});
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (mc_command == CMD_CALC) seen = 1'b1;
    end
    req = 4'b0100;
    wait_empty(200, ok);
    req = '0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_timeout: %0d jobs pending", exp_q.size()); end
    extra = 0;
    repeat (20) begin
      tick();
      if (gnt !== '0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL drop_regrant: %0d granted cycles want 0", extra); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_done = 0; n_err = 0;
    req = '0;
    stuck = 1'b0;
    d_load = 1; d_calc = 3; d_read = 1;
    for (int i = 0; i < NREQ; i++) begin
      mats[i] = rnd512();
      req_matrix[i*MW +: MW] = mats[i];
    end
    test_reset();
    test_single();
    test_all();
    test_rr_ptr();
    test_timeout();
    test_reset_mid();
    test_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
